// File: rtl/dmem_unit.sv
// Single-port byte-addressable data memory; loads sign/zero-extend, stores use byte lanes.
// Latency 1 (dataout/err registered); no backpressure, one access accepted every cycle.
module dmem_unit #(
  parameter int ADDR_BITS = 17
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [2:0]  memop,
  input  logic        we,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        err
);

  localparam int WORDS = 1 << (ADDR_BITS - 2);

  logic [31:0] r_mem [WORDS];

  logic [ADDR_BITS-3:0] w_idx;
  logic [1:0]           w_lane;
  logic                 w_bad_op;
  logic                 w_misal;
  logic                 w_err;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [31:0]          w_rword;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_load;
  logic                 w_unused;

  assign w_idx    = addr[ADDR_BITS-1:2];
  assign w_lane   = addr[1:0];
  // Bits above the decoded range simply alias.
  assign w_unused = &{1'b0, addr[31:ADDR_BITS]};

  assign w_bad_op = (memop == 3'b011) || (memop == 3'b110) || (memop == 3'b111);
  assign w_misal  = ((memop[1:0] == 2'b01) && addr[0]) ||
                    ((memop[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_err    = w_bad_op || w_misal;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = datain;
    if (we && !w_bad_op && !memop[2]) begin
      case (memop[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{datain[7:0]}};
        end
        2'b01: begin
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{datain[15:0]}};
        end
        2'b10: begin
          w_be    = 4'b1111;
          w_wdata = datain;
        end
        default: begin
          w_be    = 4'b0000;
          w_wdata = datain;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_rword = r_mem[w_idx];
  assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
  assign w_half  = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_load = 32'd0;
    case (memop)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_rword;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // An invalid memop clears dataout even when we=1; otherwise stores hold it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dataout <= 32'd0;
      err     <= 1'b0;
    end else begin
      err <= w_err;
      if (!we || w_bad_op) begin
        dataout <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboarded bench for dmem_unit: byte-array reference model, directed checks, then random traffic.
module tb_dmem_unit;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr    = 32'd0;
  logic [2:0]  memop   = 3'd0;
  logic        we      = 1'b0;
  logic [31:0] datain  = 32'd0;
  logic [31:0] dataout;
  logic        err;

  dmem_unit #(.ADDR_BITS(17)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (addr),
    .memop   (memop),
    .we      (we),
    .datain  (datain),
    .dataout (dataout),
    .err     (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mref [128];
  logic [31:0] last_d   = 32'd0;
  logic        rn       = 1'b0;
  int          n_cmp    = 0;
  int          n_bad    = 0;

  // Little-endian read of n bytes starting at byte b of the 128-byte test window.
  function automatic logic [31:0] rd(input int b, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(mref[b + k]);
    return v;
  endfunction

  task automatic issue(input logic w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] din, input string tag,
                       input bit fix = 1'b0, input logic [31:0] fd = 32'd0,
                       input logic fe = 1'b0);
    exp_t x;
    int   lo;
    bit   bad, mis;
    @(negedge clock);
    reset_n = rn;
    we      = w;
    memop   = op;
    addr    = a;
    datain  = din;
    lo  = int'(a[6:0]);
    bad = (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
    mis = ((op[1:0] == 2'd1) && a[0]) || ((op[1:0] == 2'd2) && (a[1:0] != 2'd0));
    x.tag = tag;
    x.e   = bad || mis;
    if (!rn) begin
      x.d = 32'd0; x.e = 1'b0;
    end else if (bad) begin
      x.d = 32'd0;
    end else if (w) begin
      x.d = last_d;
      case (op)
        3'd0: mref[lo] = din[7:0];
        3'd1: begin
          mref[lo & ~1]     = din[7:0];
          mref[(lo & ~1)+1] = din[15:8];
        end
        3'd2: for (int k = 0; k < 4; k++) mref[(lo & ~3) + k] = din[8*k +: 8];
        default: ;
      endcase
    end else begin
      case (op)
        3'd0: begin x.d = rd(lo, 1);        x.d = {{24{x.d[7]}},  x.d[7:0]};  end
        3'd1: begin x.d = rd(lo & ~1, 2);   x.d = {{16{x.d[15]}}, x.d[15:0]}; end
        3'd2: x.d = rd(lo & ~3, 4);
        3'd4: x.d = rd(lo, 1);
        default: x.d = rd(lo & ~1, 2);
      endcase
    end
    last_d = x.d;
    if (fix) begin
      x.d = fd; x.e = fe;
    end
    sb.push_back(x);
  endtask

  // Monitor: dataout/err reflect the access sampled on the previous edge.
  initial begin
    exp_t m;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        m = sb.pop_front();
        n_cmp++;
        if (dataout !== m.d) begin
          n_bad++;
          $display("FAIL %s dataout: got %08h want %08h", m.tag, dataout, m.d);
        end
        n_cmp++;
        if (err !== m.e) begin
          n_bad++;
          $display("FAIL %s err: got %0b want %0b", m.tag, err, m.e);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  op;
    logic        w;
    int          wait_cyc;
    // Reset with a store pending: must be dropped, outputs held at zero.
    rn = 1'b0;
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "reset0");
    issue(1'b1, 3'd2, 32'h20, 32'h1111_2222, "reset1");
    rn = 1'b1;
    for (int i = 0; i < 32; i++)
      issue(1'b1, 3'd2, 32'(i * 4), $urandom & 32'h7FFF_FFFF, "init");

    issue(1'b1, 3'd2, 32'h10, 32'h8000_00F1, "sw10");
    issue(1'b0, 3'd2, 32'h10, 32'd0, "lw10",  1'b1, 32'h8000_00F1, 1'b0);
    issue(1'b0, 3'd0, 32'h10, 32'd0, "lb10",  1'b1, 32'hFFFF_FFF1, 1'b0);
    issue(1'b0, 3'd4, 32'h10, 32'd0, "lbu10", 1'b1, 32'h0000_00F1, 1'b0);
    issue(1'b0, 3'd1, 32'h12, 32'd0, "lh12",  1'b1, 32'hFFFF_8000, 1'b0);
    issue(1'b0, 3'd5, 32'h12, 32'd0, "lhu12", 1'b1, 32'h0000_8000, 1'b0);
    issue(1'b1, 3'd0, 32'h11, 32'h0000_00AB, "sb11", 1'b1, 32'h0000_8000, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'd0, "lw10b", 1'b1, 32'h8000_ABF1, 1'b0);
    issue(1'b0, 3'd2, 32'h13, 32'd0, "lw13mis", 1'b1, 32'h8000_ABF1, 1'b1);
    issue(1'b1, 3'd3, 32'h10, 32'hFFFF_FFFF, "badop_st", 1'b1, 32'd0, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'd0, "lw10c", 1'b1, 32'h8000_ABF1, 1'b0);
    issue(1'b0, 3'd7, 32'h10, 32'd0, "badop_ld", 1'b1, 32'd0, 1'b1);
    issue(1'b1, 3'd2, 32'h0002_0004, 32'h1234_5678, "sw_wrap");
    issue(1'b0, 3'd2, 32'h4, 32'd0, "lw_wrap", 1'b1, 32'h1234_5678, 1'b0);
    issue(1'b1, 3'd1, 32'h0000_0007, 32'h0000_CAFE, "sh_mis");
    issue(1'b0, 3'd5, 32'h6, 32'd0, "lhu6", 1'b1, 32'h0000_CAFE, 1'b0);
    rn = 1'b0;
    issue(1'b1, 3'd2, 32'h20, 32'hFFFF_FFFF, "rst_sw20", 1'b1, 32'd0, 1'b0);
    rn = 1'b1;
    issue(1'b0, 3'd2, 32'h20, 32'd0, "lw20_after_rst");

    for (int i = 0; i < 800; i++) begin
      a = ($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 127));
      d = $urandom;
      w = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd0;
        3, 4:    op = 3'd1;
        5, 6:    op = 3'd2;
        7:       op = w ? 3'd0 : 3'd4;
        8:       op = w ? 3'd2 : 3'd5;
        default: op = (($urandom_range(0, 2) == 0) ? 3'd3 : (($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7));
      endcase
      rn = ($urandom_range(0, 49) != 0);
      issue(w, op, a, d, "rand");
    end
    rn = 1'b1;

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clock);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected responses left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 Parameter ADDR_BITS, default 17: byte-address width actually decoded; capacity 2^ADDR_BITS bytes, organised as 32-bit words.
REQ-002 Port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 Port addr, input, 32: byte address; bits [ADDR_BITS-1:0] used, upper bits ignored (address wraps).
REQ-005 Port memop, input, 3: access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW.
REQ-006 Port we, input, 1: write enable; 1 = store this cycle, 0 = load.
REQ-007 Port datain, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 Port dataout, output, 32: registered, extended load result.
REQ-009 Port err, output, 1: registered flag for a misaligned access or invalid memop in the previous cycle.

Function
REQ-010 Word index is addr[ADDR_BITS-1:2]; byte lane is addr[1:0].
REQ-011 Store when we=1 and reset_n=1: SB writes datain[7:0] to lane addr[1:0]; SH writes datain[15:0] to lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes; unaddressed lanes are unchanged.
REQ-012 Byte order is little-endian: lane 0 = word bits [7:0], lane 3 = bits [31:24].
REQ-013 Load when we=0: dataout is updated on the rising edge that samples addr/memop, so the result is valid one cycle later (latency 1).
REQ-014 LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW returns the full word.
REQ-015 When we=1, dataout holds its previous value.
REQ-016 Halfword access ignores addr[0]; word access ignores addr[1:0]; the access still completes on the aligned location.
REQ-017 err is set to 1 for one cycle when: addr[0]=1 on a halfword access; addr[1:0]!=00 on a word access; or memop is 011, 110 or 111. Otherwise err is set to 0.
REQ-018 Invalid memop: no lane is written and dataout is loaded with 0.
REQ-019 A load and a store are never issued in the same cycle (single port); back-to-back store then load to the same address returns the newly stored data in the cycle after the load.
REQ-020 Addresses at or above 2^ADDR_BITS alias onto lower addresses.
REQ-021 Memory contents are not initialised by reset; contents are undefined until written.

Reset
REQ-022 While reset_n=0 at a rising edge: dataout <= 0, err <= 0, and no write occurs regardless of we.
REQ-023 A store asserted in the same cycle that reset_n is low is dropped and not replayed after reset.
REQ-024 The first access after reset_n returns to 1 behaves normally, with latency 1.

Verification
REQ-025 SW 0x8000_00F1 to addr 0x10, then LW 0x10 -> dataout=0x8000_00F1 one cycle after the load, err=0.
REQ-026 After REQ-025: LB 0x10 -> 0xFFFF_FFF1; LBU 0x10 -> 0x0000_00F1; LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000.
REQ-027 SB 0xAB to addr 0x11 over word 0x8000_00F1, then LW 0x10 -> 0x8000_ABF1; a lane not addressed is unchanged.
REQ-028 LW at 0x13 -> err=1, dataout = word at 0x10; memop=011 with we=1 -> err=1, memory unchanged.
REQ-029 SW 0x1234_5678 to addr 0x0002_0004 (ADDR_BITS=17) -> LW 0x4 returns 0x1234_5678 (wrap-around).
REQ-030 reset_n=0 with we=1, SW 0xFFFF_FFFF to 0x20 -> dataout=0, err=0; after release, LW 0x20 does not return 0xFFFF_FFFF unless it was previously written.
